// File: rtl/boa_spirom_pkg.sv
// Shared types and constants for the read-only SPI NOR flash controller.
package boa_spirom_pkg;

  typedef enum logic [2:0] {
    INIT_CMD  = 3'd0,
    INIT_WAIT = 3'd1,
    IDLE      = 3'd2,
    CMD       = 3'd3,
    ADDR      = 3'd4,
    DATA      = 3'd5,
    DONE      = 3'd6
  } spirom_state_t;

  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_WAKE   = 8'hAB;
  localparam int         BITS_CMD  = 8;
  localparam int         BITS_ADDR = 24;
  localparam int         BITS_DATA = 32;

  // Flash bytes arrive in address order with byte 0 first; the bus wants byte 0 in the low lane.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/boa_spi_shift.sv
// Mode-0 SPI bit engine: SCLK divider plus 32-bit transmit/receive shift registers.
// Transmit data is left-justified (bit 31 goes out first). A new start may be
// issued in the cycle last_o is high so that consecutive segments run seamlessly.
module boa_spi_shift #(
  parameter int div = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [5:0]  nbits_i,
  input  logic [31:0] tx_i,
  input  logic        miso_i,
  output logic        busy_o,
  output logic        last_o,
  output logic [31:0] rx_o,
  output logic        sclk_o,
  output logic        mosi_o
);

  localparam int             CW      = (div > 1) ? $clog2(div) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(div - 1);

  logic          busy_q, busy_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  logic [5:0]    bits_q, bits_d;
  logic [31:0]   sh_q,   sh_d;
  logic [31:0]   rx_q,   rx_d;

  // Final clk cycle of the high phase of the final bit of the segment.
  assign last_o = busy_q && sclk_q && (cnt_q == CNT_MAX) && (bits_q == 6'd0);
  assign busy_o = busy_q;
  assign rx_o   = rx_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;

  // Next-state logic: low phase then high phase per bit, MOSI updated entering low, MISO sampled on the rise.
  always_comb begin
    busy_d = busy_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    cnt_d  = cnt_q;
    bits_d = bits_q;
    sh_d   = sh_q;
    rx_d   = rx_q;
    if (start_i) begin
      busy_d = 1'b1;
      sclk_d = 1'b0;
      cnt_d  = {CW{1'b0}};
      bits_d = nbits_i - 6'd1;
      mosi_d = tx_i[31];
      sh_d   = {tx_i[30:0], 1'b0};
    end else if (busy_q) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = {CW{1'b0}};
        if (!sclk_q) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[30:0], miso_i};
        end else if (bits_q == 6'd0) begin
          busy_d = 1'b0;
          sclk_d = 1'b0;
          mosi_d = 1'b0;
        end else begin
          sclk_d = 1'b0;
          bits_d = bits_q - 6'd1;
          mosi_d = sh_q[31];
          sh_d   = {sh_q[30:0], 1'b0};
        end
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Shifter registers with synchronous reset to an idle, SCLK-low bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      cnt_q  <= {CW{1'b0}};
      bits_q <= 6'd0;
      sh_q   <= 32'd0;
      rx_q   <= 32'd0;
    end else begin
      busy_q <= busy_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      cnt_q  <= cnt_d;
      bits_q <= bits_d;
      sh_q   <= sh_d;
      rx_q   <= rx_d;
    end
  end

endmodule

// File: rtl/boa_extmem_spirom.sv
// Read-only SPI NOR flash controller for the external-ROM memory bus.
// Wakes the flash with 0xAB, then serves one-word READ (0x03) transactions,
// with a one-entry last-word buffer that answers repeat fetches without SPI traffic.
module boa_extmem_spirom
  import boa_spirom_pkg::*;
#(
  parameter int alen      = 19,
  parameter int div       = 2,
  parameter int init_wait = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bus_re,
  input  logic [3:0]      bus_we,
  input  logic [alen-1:0] bus_addr,
  input  logic [31:0]     bus_wdata,
  output logic [31:0]     bus_rdata,
  output logic            bus_ready,
  output logic            spi_sclk,
  output logic            spi_cs_n,
  output logic            spi_mosi,
  input  logic            spi_miso
);

  localparam int             TW       = alen - 2;
  localparam int             WW       = $clog2(init_wait + 1);
  localparam logic [WW-1:0]  WAIT_MAX = WW'(init_wait - 1);
  localparam int             GW       = $clog2(2 * div) + 1;
  localparam logic [GW-1:0]  GAP_MAX  = GW'(2 * div - 1);

  spirom_state_t state_q, state_d;
  logic          cs_n_q,  cs_n_d;
  logic [TW-1:0] addr_q,  addr_d;
  logic [TW-1:0] tag_q,   tag_d;
  logic          valid_q, valid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [WW-1:0] wait_q,  wait_d;
  logic [GW-1:0] gap_q,   gap_d;

  logic          start_s;
  logic [5:0]    nbits_s;
  logic [31:0]   tx_s;
  logic          shift_busy_s;
  logic          shift_last_s;
  logic [31:0]   shift_rx_s;
  logic [23:0]   flash_addr_s;
  logic          hit_s;
  logic          ready_s;
  logic          unused_s;

  // Write data and byte offset have no meaning for a ROM.
  assign unused_s     = ^{bus_wdata, bus_addr[1:0]};
  assign flash_addr_s = {22'(addr_q), 2'b00};
  assign hit_s        = valid_q && (tag_q == bus_addr[alen-1:2]);

  boa_spi_shift #(.div(div)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_s),
    .nbits_i (nbits_s),
    .tx_i    (tx_s),
    .miso_i  (spi_miso),
    .busy_o  (shift_busy_s),
    .last_o  (shift_last_s),
    .rx_o    (shift_rx_s),
    .sclk_o  (spi_sclk),
    .mosi_o  (spi_mosi)
  );

  // Bus handshake: idle and writes complete at once; reads complete on a buffer hit or in DONE.
  always_comb begin
    ready_s = 1'b0;
    if (bus_we != 4'h0) begin
      ready_s = 1'b1;
    end else if (!bus_re) begin
      ready_s = 1'b1;
    end else if (state_q == DONE) begin
      ready_s = 1'b1;
    end else if (hit_s) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign bus_ready = ready_s;
  assign bus_rdata = rdata_q;
  assign spi_cs_n  = cs_n_q;

  // Counts clk cycles with CS high so back-to-back reads keep the minimum deselect time.
  always_comb begin
    gap_d = gap_q;
    if (!cs_n_q) begin
      gap_d = {GW{1'b0}};
    end else if (gap_q != GAP_MAX) begin
      gap_d = gap_q + GW'(1);
    end else begin
      gap_d = gap_q;
    end
  end

  // Transaction sequencer: drives CS and hands command/address/data segments to the shifter.
  always_comb begin
    state_d = state_q;
    cs_n_d  = cs_n_q;
    addr_d  = addr_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    wait_d  = wait_q;
    start_s = 1'b0;
    nbits_s = 6'd0;
    tx_s    = 32'd0;
    case (state_q)
      INIT_CMD: begin
        if (cs_n_q) begin
          cs_n_d = 1'b0;
        end else if (!shift_busy_s) begin
          start_s = 1'b1;
          nbits_s = 6'(BITS_CMD);
          tx_s    = {OP_WAKE, 24'h000000};
        end else if (shift_last_s) begin
          cs_n_d  = 1'b1;
          wait_d  = {WW{1'b0}};
          state_d = INIT_WAIT;
        end else begin
          state_d = INIT_CMD;
        end
      end
      INIT_WAIT: begin
        if (wait_q == WAIT_MAX) begin
          state_d = IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      IDLE: begin
        if (bus_re && (bus_we == 4'h0) && !hit_s && (gap_q == GAP_MAX)) begin
          addr_d  = bus_addr[alen-1:2];
          cs_n_d  = 1'b0;
          state_d = CMD;
        end else begin
          state_d = IDLE;
        end
      end
      CMD: begin
        if (!shift_busy_s) begin
          start_s = 1'b1;
          nbits_s = 6'(BITS_CMD);
          tx_s    = {OP_READ, 24'h000000};
        end else if (shift_last_s) begin
          start_s = 1'b1;
          nbits_s = 6'(BITS_ADDR);
          tx_s    = {flash_addr_s, 8'h00};
          state_d = ADDR;
        end else begin
          state_d = CMD;
        end
      end
      ADDR: begin
        if (shift_last_s) begin
          start_s = 1'b1;
          nbits_s = 6'(BITS_DATA);
          tx_s    = 32'd0;
          state_d = DATA;
        end else begin
          state_d = ADDR;
        end
      end
      DATA: begin
        if (shift_last_s) begin
          rdata_d = byte_swap32(shift_rx_s);
          cs_n_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = DATA;
        end
      end
      DONE: begin
        tag_d   = addr_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        cs_n_d  = 1'b1;
        state_d = INIT_CMD;
      end
    endcase
  end

  // Controller registers; reset deselects the flash, drops the buffer and restarts the wake sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT_CMD;
      cs_n_q  <= 1'b1;
      addr_q  <= {TW{1'b0}};
      tag_q   <= {TW{1'b0}};
      valid_q <= 1'b0;
      rdata_q <= 32'd0;
      wait_q  <= {WW{1'b0}};
      gap_q   <= {GW{1'b0}};
    end else begin
      state_q <= state_d;
      cs_n_q  <= cs_n_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      wait_q  <= wait_d;
      gap_q   <= gap_d;
    end
  end

endmodule

// File: tb/tb_boa_extmem_spirom.sv
// Self-checking bench for boa_extmem_spirom with a behavioural SPI flash (byte[i] = i[7:0] ^ 8'h5A).
module tb_boa_extmem_spirom;

  localparam int ALEN = 19;
  localparam int DIV  = 2;
  localparam int LAT  = 1 + 64 * 2 * DIV + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            bus_re;
  logic [3:0]      bus_we;
  logic [ALEN-1:0] bus_addr;
  logic [31:0]     bus_wdata;
  logic [31:0]     bus_rdata;
  logic            bus_ready;
  logic            spi_sclk;
  logic            spi_cs_n;
  logic            spi_mosi;
  logic            spi_miso = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] exp_q[$];

  // flash model state
  int          rise_cnt = 0;
  logic [63:0] mosi_cap = 64'd0;
  logic [23:0] fl_addr  = 24'd0;
  int          cs_falls = 0;
  int          fall_cyc = 0;
  int          frame_bits_q[$];
  logic [63:0] frame_word_q[$];
  int          frame_rise_q[$];
  int          frame_fall_q[$];

  boa_extmem_spirom #(.alen(ALEN), .div(DIV), .init_wait(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_re    (bus_re),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    logic [31:0] r;
    logic [23:0] b;
    r = 32'd0;
    for (int k = 0; k < 4; k++) begin
      b = {a[23:2], 2'b00} + 24'(k);
      r[8*k +: 8] = b[7:0] ^ 8'h5A;
    end
    return r;
  endfunction

  function automatic logic flash_bit(input logic [63:0] cap, input logic [23:0] fa, input int rc);
    int          d;
    logic [23:0] a;
    logic [7:0]  b;
    d = rc - 32;
    a = ((d == 0) ? cap[23:0] : fa) + 24'(d / 8);
    b = a[7:0] ^ 8'h5A;
    return b[7 - (d % 8)];
  endfunction

  // Command/address capture on rising SCLK; CS high clears the frame.
  always @(posedge spi_sclk or posedge spi_cs_n) begin
    if (spi_cs_n) begin
      rise_cnt <= 0;
      mosi_cap <= 64'd0;
    end else begin
      rise_cnt <= rise_cnt + 1;
      mosi_cap <= {mosi_cap[62:0], spi_mosi};
    end
  end

  // Read data driven on falling SCLK once 8 command + 24 address bits were seen.
  always @(negedge spi_sclk) begin
    if (spi_cs_n === 1'b0 && rise_cnt >= 32) begin
      if (rise_cnt == 32) fl_addr <= mosi_cap[23:0];
      spi_miso <= flash_bit(mosi_cap, fl_addr, rise_cnt);
    end
  end

  always @(negedge spi_cs_n) begin
    cs_falls <= cs_falls + 1;
    fall_cyc <= cyc;
  end

  always @(posedge spi_cs_n) begin
    if (rise_cnt != 0) begin
      frame_bits_q.push_back(rise_cnt);
      frame_word_q.push_back(mosi_cap);
      frame_rise_q.push_back(cyc);
      frame_fall_q.push_back(fall_cyc);
    end
  end

  task automatic wait_ready(input int bound, output int n, output bit to);
    n  = 0;
    to = 1'b0;
    #1;
    while (bus_ready !== 1'b1) begin
      if (n >= bound) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus_re = 1'b0; bus_we = 4'h0; bus_addr = '0; bus_wdata = 32'd0;
    repeat (3) @(negedge clk);
    checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b want 1", spi_cs_n); end
    checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", spi_sclk); end
    checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", spi_mosi); end
    checks++; if (bus_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus_rdata); end
    checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL reset_idle_ready got %b want 1", bus_ready); end
  endtask

  task automatic test_init_read();
    int n; bit to; int f0; logic [31:0] e;
    f0 = frame_bits_q.size();
    rst = 1'b0; bus_re = 1'b1; bus_addr = 19'h00010;
    exp_q.push_back(exp_word(24'h000010));
    wait_ready(2000, n, to);
    checks++; if (to) begin errors++; $display("FAIL init_read_timeout cycles %0d", n); end
    checks++; if (frame_bits_q.size() != f0 + 2) begin errors++;
      $display("FAIL init_ready_early frames %0d want %0d", frame_bits_q.size() - f0, 2); end
    e = exp_q.pop_front();
    checks++; if (bus_rdata !== e) begin errors++; $display("FAIL init_read_rdata got %h want %h", bus_rdata, e); end
    if (frame_bits_q.size() >= f0 + 2) begin
      checks++; if (frame_bits_q[f0] != 8 || frame_word_q[f0][7:0] !== 8'hAB) begin errors++;
        $display("FAIL wake_frame bits %0d byte %h want 8 ab", frame_bits_q[f0], frame_word_q[f0][7:0]); end
      checks++; if (frame_fall_q[f0+1] - frame_rise_q[f0] < 64) begin errors++;
        $display("FAIL init_wait_gap got %0d want >=64", frame_fall_q[f0+1] - frame_rise_q[f0]); end
      checks++; if (frame_bits_q[f0+1] != 64 || frame_word_q[f0+1][63:32] !== 32'h03000010) begin errors++;
        $display("FAIL read_frame_0x10 bits %0d mosi %h want 64 03000010", frame_bits_q[f0+1], frame_word_q[f0+1][63:32]); end
    end
    @(negedge clk); bus_re = 1'b0;
  endtask

  task automatic test_hit();
    int f; logic [31:0] e;
    repeat (5) @(negedge clk);
    f = cs_falls;
    bus_re = 1'b1; bus_addr = 19'h00012;
    exp_q.push_back(exp_word(24'h000012));
    #1;
    e = exp_q.pop_front();
    checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL hit_ready got %b want 1", bus_ready); end
    checks++; if (bus_rdata !== e) begin errors++; $display("FAIL hit_rdata got %h want %h", bus_rdata, e); end
    repeat (4) @(negedge clk);
    checks++; if (cs_falls != f) begin errors++; $display("FAIL hit_no_spi cs_falls got %0d want %0d", cs_falls, f); end
    bus_re = 1'b0;
  endtask

  task automatic test_write();
    int f; logic [31:0] e;
    @(negedge clk);
    f = cs_falls;
    bus_we = 4'hF; bus_addr = 19'h00020; bus_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL write_ready got %b want 1", bus_ready); end
    repeat (20) @(negedge clk);
    bus_we = 4'h0; bus_re = 1'b1; bus_addr = 19'h00010;
    exp_q.push_back(exp_word(24'h000010));
    #1;
    e = exp_q.pop_front();
    checks++; if (bus_ready !== 1'b1 || bus_rdata !== e) begin errors++;
      $display("FAIL buffer_after_write ready %b rdata %h want 1 %h", bus_ready, bus_rdata, e); end
    @(negedge clk);
    bus_we = 4'hF; bus_re = 1'b1; bus_addr = 19'h00040;
    #1;
    checks++; if (bus_ready !== 1'b1) begin errors++; $display("FAIL re_we_ready got %b want 1", bus_ready); end
    repeat (20) @(negedge clk);
    checks++; if (cs_falls != f) begin errors++; $display("FAIL write_no_spi cs_falls got %0d want %0d", cs_falls, f); end
    bus_we = 4'h0; bus_re = 1'b0;
  endtask

  task automatic test_wrap_latency();
    int n; bit to; int f0; logic [31:0] e;
    repeat (10) @(negedge clk);
    f0 = frame_bits_q.size();
    bus_re = 1'b1; bus_addr = 19'h7FFFC;
    exp_q.push_back(exp_word(24'h07FFFC));
    wait_ready(1000, n, to);
    checks++; if (to || n != LAT) begin errors++; $display("FAIL wrap_latency got %0d want %0d", n, LAT); end
    e = exp_q.pop_front();
    checks++; if (bus_rdata !== e) begin errors++; $display("FAIL wrap_rdata got %h want %h", bus_rdata, e); end
    checks++; if (frame_bits_q.size() != f0 + 1) begin errors++;
      $display("FAIL wrap_frame_count got %0d want 1", frame_bits_q.size() - f0); end
    else begin
      checks++; if (frame_word_q[f0][63:32] !== 32'h0307FFFC) begin errors++;
        $display("FAIL wrap_mosi got %h want 0307fffc", frame_word_q[f0][63:32]); end
    end
    @(negedge clk); bus_re = 1'b0;
  endtask

  task automatic test_re_drop();
    int n; int f0; int f; logic [31:0] e;
    repeat (10) @(negedge clk);
    f0 = frame_bits_q.size();
    bus_re = 1'b1; bus_addr = 19'h00100;
    exp_q.push_back(exp_word(24'h000100));
    n = 0;
    while (rise_cnt < 16 && n < 300) begin @(negedge clk); n++; end
    bus_re = 1'b0;
    checks++; if (rise_cnt < 9 || rise_cnt > 31) begin errors++; $display("FAIL drop_in_addr rise %0d want 9..31", rise_cnt); end
    n = 0;
    while (frame_bits_q.size() == f0 && n < 400) begin @(negedge clk); n++; end
    checks++; if (frame_bits_q.size() != f0 + 1 || frame_bits_q[f0] != 64) begin errors++;
      $display("FAIL drop_completes frames %0d want 1", frame_bits_q.size() - f0); end
    repeat (3) @(negedge clk);
    f = cs_falls;
    bus_re = 1'b1;
    #1;
    e = exp_q.pop_front();
    checks++; if (bus_ready !== 1'b1 || bus_rdata !== e) begin errors++;
      $display("FAIL drop_then_hit ready %b rdata %h want 1 %h", bus_ready, bus_rdata, e); end
    repeat (3) @(negedge clk);
    checks++; if (cs_falls != f) begin errors++; $display("FAIL drop_hit_no_spi got %0d want %0d", cs_falls, f); end
    bus_re = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n; bit to; int f; logic [31:0] e;
    repeat (10) @(negedge clk);
    bus_re = 1'b1; bus_addr = 19'h00200;
    n = 0;
    while (rise_cnt < 44 && n < 400) begin @(negedge clk); n++; end
    checks++; if (rise_cnt != 44) begin errors++; $display("FAIL reach_data_bit12 rise %0d want 44", rise_cnt); end
    rst = 1'b1; bus_re = 1'b0;
    @(negedge clk);
    checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL midreset_cs_n got %b want 1", spi_cs_n); end
    checks++; if (bus_rdata !== 32'd0) begin errors++; $display("FAIL midreset_rdata got %h want 0", bus_rdata); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    f = cs_falls;
    bus_re = 1'b1; bus_addr = 19'h00100;
    exp_q.push_back(exp_word(24'h000100));
    wait_ready(1000, n, to);
    checks++; if (to || n != LAT) begin errors++; $display("FAIL invalidated_latency got %0d want %0d", n, LAT); end
    checks++; if (cs_falls != f + 1) begin errors++; $display("FAIL invalidated_spi cs_falls got %0d want %0d", cs_falls, f + 1); end
    e = exp_q.pop_front();
    checks++; if (bus_rdata !== e) begin errors++; $display("FAIL invalidated_rdata got %h want %h", bus_rdata, e); end
    @(negedge clk); bus_re = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_read();
    test_hit();
    test_write();
    test_wrap_latency();
    test_re_drop();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
